// File: rtl/spi_rom_reader.sv
// SPI serial-ROM read sequencer: streams a read command into the SPI TX FIFO and returns the data bytes.
// Optional SPI_ROM_FAST_READ_EN selects fast-read opcode 0x0B with one dummy byte.
module spi_rom_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [6:0]  req_len,
    output logic [8:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_full,
    input  logic [7:0]  rx_data,
    output logic        rx_rd,
    input  logic        rx_empty,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        busy,
    output logic        err
);

`ifdef SPI_ROM_FAST_READ_EN
    localparam logic [6:0] HLEN   = 7'd5;
    localparam logic [7:0] OPCODE = 8'h0B;
`else
    localparam logic [6:0] HLEN   = 7'd4;
    localparam logic [7:0] OPCODE = 8'h03;
`endif
    localparam logic [6:0] MAX_LEN = 7'd127 - HLEN;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_CMD,
        S_ADDR2,
        S_ADDR1,
        S_ADDR0,
        S_DUMMY,
        S_FILL,
        S_DRAIN
    } state_t;

    state_t      state;
    logic [23:0] addr_q;
    logic [6:0]  fill_cnt;
    logic [6:0]  out_cnt;
    logic [6:0]  pop_cnt;
    logic [6:0]  disc_cnt;
    logic        pend;

    logic       tx_acc;
    logic       out_acc;
    logic       last_out;
    logic       len_bad;
    logic [6:0] total;

    assign tx_acc   = tx_wr & ~tx_full;
    assign out_acc  = dout_valid & dout_ready;
    assign last_out = out_acc & (out_cnt == 7'd1);
    assign len_bad  = (req_len == 7'd0) | (req_len > MAX_LEN);
    assign total    = HLEN + req_len;

    // Only one pop in flight, and only when its byte has somewhere to land.
    assign rx_rd = ~rst & (pop_cnt != 7'd0) & ~pend & ~rx_empty
                 & (~dout_valid | dout_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= 24'h0;
            fill_cnt   <= 7'd0;
            out_cnt    <= 7'd0;
            pop_cnt    <= 7'd0;
            disc_cnt   <= 7'd0;
            pend       <= 1'b0;
            tx_data    <= 9'h0;
            tx_wr      <= 1'b0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            err  <= 1'b0;
            pend <= rx_rd;
            if (rx_rd)
                pop_cnt <= pop_cnt - 7'd1;
            if (out_acc) begin
                dout_valid <= 1'b0;
                out_cnt    <= out_cnt - 7'd1;
            end
            // Returned byte: drop the command echo, else load dout.
            if (pend) begin
                if (disc_cnt != 7'd0) begin
                    disc_cnt <= disc_cnt - 7'd1;
                end else begin
                    dout       <= rx_data;
                    dout_valid <= 1'b1;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        if (len_bad) begin
                            err <= 1'b1;
                        end else begin
                            addr_q    <= req_addr;
                            fill_cnt  <= req_len;
                            out_cnt   <= req_len;
                            pop_cnt   <= total;
                            disc_cnt  <= HLEN;
                            tx_data   <= {1'b1, 1'b0, total};
                            tx_wr     <= 1'b1;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                            state     <= S_HDR;
                        end
                    end
                end
                S_HDR: begin
                    if (tx_acc) begin
                        tx_data <= {1'b0, OPCODE};
                        state   <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (tx_acc) begin
                        tx_data <= {1'b0, addr_q[23:16]};
                        state   <= S_ADDR2;
                    end
                end
                S_ADDR2: begin
                    if (tx_acc) begin
                        tx_data <= {1'b0, addr_q[15:8]};
                        state   <= S_ADDR1;
                    end
                end
                S_ADDR1: begin
                    if (tx_acc) begin
                        tx_data <= {1'b0, addr_q[7:0]};
                        state   <= S_ADDR0;
                    end
                end
                S_ADDR0: begin
                    if (tx_acc) begin
                        tx_data <= 9'h0FF;
`ifdef SPI_ROM_FAST_READ_EN
                        state   <= S_DUMMY;
`else
                        state   <= S_FILL;
`endif
                    end
                end
                S_DUMMY: begin
                    if (tx_acc) begin
                        tx_data <= 9'h0FF;
                        state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (tx_acc) begin
                        fill_cnt <= fill_cnt - 7'd1;
                        if (fill_cnt == 7'd1) begin
                            tx_wr <= 1'b0;
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((out_cnt == 7'd0) || last_out) begin
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rom_reader.sv
// Self-checking bench for spi_rom_reader: FIFO models, a command/data
// reference model and randomized flow control.
module tb_spi_rom_reader;

`ifdef SPI_ROM_FAST_READ_EN
    localparam int H = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int H = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif
    localparam int MAXLEN = 127 - H;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [6:0]  req_len;
    logic [8:0]  tx_data;
    logic        tx_wr;
    logic        tx_full;
    logic [7:0]  rx_data;
    logic        rx_rd;
    logic        rx_empty;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    spi_rom_reader dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
        .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .err(err)
    );

    int checks = 0;
    int errors = 0;

    logic full_man, ready_man, rand_mode;
    logic rnd_full, rnd_ready, rnd_block;
    logic [7:0] rx_mem [256];
    int rx_wp = 0;
    int rx_rp = 0;
    int tx_cnt = 0;
    logic [8:0] tx_log [$];
    logic [7:0] out_log [$];
    logic [8:0] exp_tx [$];
    logic [7:0] inj_q [$];

    assign tx_full    = rand_mode ? rnd_full : full_man;
    assign dout_ready = rand_mode ? rnd_ready : ready_man;
    assign rx_empty   = (rx_rp == rx_wp) || (rand_mode && rnd_block);

    always @(negedge clk) begin
        rnd_full  <= ($urandom_range(0, 3) == 0);
        rnd_ready <= ($urandom_range(0, 3) != 0);
        rnd_block <= ($urandom_range(0, 4) == 0);
    end

    always @(posedge clk) begin
        if (tx_wr && !tx_full) begin
            tx_log.push_back(tx_data);
            tx_cnt <= tx_cnt + 1;
        end
        if (dout_valid && dout_ready)
            out_log.push_back(dout);
        if (rx_rd && !rx_empty) begin
            rx_data <= rx_mem[rx_rp[7:0]];
            rx_rp   <= rx_rp + 1;
        end
    end

    // Reference: the full TX word sequence a read of n bytes at a must produce.
    task automatic build_exp(input logic [23:0] a, input int n);
        exp_tx.delete();
        exp_tx.push_back({2'b10, 7'(H + n)});
        exp_tx.push_back({1'b0, OPC});
        exp_tx.push_back({1'b0, a[23:16]});
        exp_tx.push_back({1'b0, a[15:8]});
        exp_tx.push_back({1'b0, a[7:0]});
        if (H == 5) exp_tx.push_back(9'h0FF);
        for (int i = 0; i < n; i++) exp_tx.push_back(9'h0FF);
    endtask

    task automatic inject(input int n, input bit seq);
        logic [7:0] b;
        inj_q.delete();
        for (int i = 0; i < n; i++) begin
            b = seq ? 8'(8'hA0 + i) : 8'($urandom);
            rx_mem[rx_wp[7:0]] = b;
            rx_wp = rx_wp + 1;
            inj_q.push_back(b);
        end
    endtask

    task automatic issue(input logic [23:0] a, input int n);
        @(negedge clk);
        req_addr  = a;
        req_len   = 7'(n);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, busy, tx_wr, rx_rd, dout_valid, err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 100000",
                     {req_ready, busy, tx_wr, rx_rd, dout_valid, err});
        end
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout got %h exp 00", dout);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b busy=%b exp 1 0", req_ready, busy);
        end
    endtask

    task automatic test_basic();
        int tb0, ob0;
        bit ok;
        logic [8:0] g;
        logic [7:0] gb;
        tb0 = tx_log.size();
        ob0 = out_log.size();
        inject(H + 3, 1'b1);
        build_exp(24'h001234, 3);
        issue(24'h001234, 3);
        wait_idle(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done got busy=1 exp busy=0");
        end
        checks++;
        if (tx_log.size() - tb0 != exp_tx.size()) begin
            errors++;
            $display("FAIL basic_tx_count got %0d exp %0d",
                     tx_log.size() - tb0, exp_tx.size());
        end
        for (int i = 0; i < exp_tx.size(); i++) begin
            g = (tb0 + i < tx_log.size()) ? tx_log[tb0 + i] : 9'hxxx;
            checks++;
            if (g !== exp_tx[i]) begin
                errors++;
                $display("FAIL basic_tx[%0d] got %h exp %h", i, g, exp_tx[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            gb = (ob0 + i < out_log.size()) ? out_log[ob0 + i] : 8'hxx;
            checks++;
            if (gb !== inj_q[H + i]) begin
                errors++;
                $display("FAIL basic_dout[%0d] got %h exp %h", i, gb, inj_q[H + i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int tb0;
        bit ok, found;
        logic [8:0] g;
        tb0 = tx_log.size();
        inject(H + 3, 1'b1);
        build_exp(24'h001234, 3);
        issue(24'h001234, 3);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_wr && tx_data == 9'h012) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_reach_addr1 got none exp tx_data 012");
        end
        full_man = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tx_wr !== 1'b1 || tx_data !== 9'h012) begin
                errors++;
                $display("FAIL bp_hold[%0d] got wr=%b data=%h exp 1 012", i, tx_wr, tx_data);
            end
        end
        full_man = 1'b0;
        wait_idle(200, ok);
        checks++;
        if (!ok || tx_log.size() - tb0 != exp_tx.size()) begin
            errors++;
            $display("FAIL bp_tx_count got %0d exp %0d", tx_log.size() - tb0, exp_tx.size());
        end
        for (int i = 0; i < exp_tx.size(); i++) begin
            g = (tb0 + i < tx_log.size()) ? tx_log[tb0 + i] : 9'hxxx;
            checks++;
            if (g !== exp_tx[i]) begin
                errors++;
                $display("FAIL bp_tx[%0d] got %h exp %h", i, g, exp_tx[i]);
            end
        end
    endtask

    task automatic test_stall();
        int ob0;
        bit ok, found;
        logic [7:0] held, gb;
        ob0 = out_log.size();
        ready_man = 1'b0;
        inject(H + 4, 1'b0);
        issue(24'hABCDEF, 4);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (dout_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found || dout !== inj_q[H] || rx_wp - rx_rp != 3) begin
            errors++;
            $display("FAIL stall_first got v=%b d=%h q=%0d exp 1 %h 3",
                     dout_valid, dout, rx_wp - rx_rp, inj_q[H]);
        end
        held = dout;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rx_rd !== 1'b0 || dout_valid !== 1'b1 || dout !== held) begin
                errors++;
                $display("FAIL stall_hold[%0d] got rd=%b v=%b d=%h exp 0 1 %h",
                         i, rx_rd, dout_valid, dout, held);
            end
        end
        ready_man = 1'b1;
        wait_idle(200, ok);
        checks++;
        if (!ok || out_log.size() - ob0 != 4) begin
            errors++;
            $display("FAIL stall_count got %0d exp 4", out_log.size() - ob0);
        end
        for (int i = 0; i < 4; i++) begin
            gb = (ob0 + i < out_log.size()) ? out_log[ob0 + i] : 8'hxx;
            checks++;
            if (gb !== inj_q[H + i]) begin
                errors++;
                $display("FAIL stall_dout[%0d] got %h exp %h", i, gb, inj_q[H + i]);
            end
        end
    endtask

    task automatic test_reject();
        int c0;
        int bad [2];
        bad[0] = 0;
        bad[1] = MAXLEN + 1;
        for (int k = 0; k < 2; k++) begin
            c0 = tx_cnt;
            @(negedge clk);
            req_addr  = 24'h123456;
            req_len   = 7'(bad[k]);
            req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            checks++;
            if (err !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reject_pulse len=%0d got err=%b rdy=%b busy=%b exp 1 1 0",
                         bad[k], err, req_ready, busy);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL reject_width len=%0d got err=%b exp 0", bad[k], err);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (tx_cnt != c0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL reject_quiet len=%0d got writes=%0d rdy=%b exp 0 1",
                         bad[k], tx_cnt - c0, req_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int tb0, ob0, c1, rp1;
        bit ok, found;
        logic [8:0] g;
        logic [7:0] gb;
        inject(H + 50, 1'b0);
        issue(24'h00BEEF, 50);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_wr && tx_data == 9'h0FF) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (!found || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_fill got busy=%b exp in FILL", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, busy, tx_wr, rx_rd, dout_valid, err} !== 6'b100000
            || dout !== 8'h00) begin
            errors++;
            $display("FAIL rmid_reset got %b dout=%h exp 100000 00",
                     {req_ready, busy, tx_wr, rx_rd, dout_valid, err}, dout);
        end
        rst = 1'b0;
        c1 = tx_cnt;
        rp1 = rx_rp;
        repeat (5) @(negedge clk);
        checks++;
        if (tx_cnt != c1 || rx_rp != rp1) begin
            errors++;
            $display("FAIL rmid_quiet got writes=%0d pops=%0d exp 0 0",
                     tx_cnt - c1, rx_rp - rp1);
        end
        rx_wp = rx_rp;
        tb0 = tx_log.size();
        ob0 = out_log.size();
        inject(H + 1, 1'b0);
        build_exp(24'h7A0001, 1);
        issue(24'h7A0001, 1);
        wait_idle(200, ok);
        checks++;
        if (!ok || tx_log.size() - tb0 != exp_tx.size()) begin
            errors++;
            $display("FAIL rmid_tx_count got %0d exp %0d", tx_log.size() - tb0, exp_tx.size());
        end
        for (int i = 0; i < exp_tx.size(); i++) begin
            g = (tb0 + i < tx_log.size()) ? tx_log[tb0 + i] : 9'hxxx;
            checks++;
            if (g !== exp_tx[i]) begin
                errors++;
                $display("FAIL rmid_tx[%0d] got %h exp %h", i, g, exp_tx[i]);
            end
        end
        gb = (ob0 < out_log.size()) ? out_log[ob0] : 8'hxx;
        checks++;
        if (gb !== inj_q[H] || out_log.size() - ob0 != 1) begin
            errors++;
            $display("FAIL rmid_dout got %h n=%0d exp %h n=1", gb, out_log.size() - ob0, inj_q[H]);
        end
    endtask

    task automatic test_random();
        int tb0, ob0, n;
        bit ok;
        logic [23:0] a;
        logic [8:0] g;
        logic [7:0] gb;
        for (int it = 0; it < 8; it++) begin
            n = (it == 0) ? MAXLEN : int'($urandom_range(1, 20));
            a = 24'($urandom);
            tb0 = tx_log.size();
            ob0 = out_log.size();
            inject(H + n, 1'b0);
            build_exp(a, n);
            rand_mode = 1'b1;
            issue(a, n);
            wait_idle(5000, ok);
            rand_mode = 1'b0;
            @(negedge clk);
            checks++;
            if (!ok || tx_log.size() - tb0 != exp_tx.size()
                || out_log.size() - ob0 != n) begin
                errors++;
                $display("FAIL rand%0d_counts got tx=%0d out=%0d exp %0d %0d",
                         it, tx_log.size() - tb0, out_log.size() - ob0, exp_tx.size(), n);
            end
            for (int i = 0; i < exp_tx.size(); i++) begin
                g = (tb0 + i < tx_log.size()) ? tx_log[tb0 + i] : 9'hxxx;
                checks++;
                if (g !== exp_tx[i]) begin
                    errors++;
                    $display("FAIL rand%0d_tx[%0d] got %h exp %h", it, i, g, exp_tx[i]);
                end
            end
            for (int i = 0; i < n; i++) begin
                gb = (ob0 + i < out_log.size()) ? out_log[ob0 + i] : 8'hxx;
                checks++;
                if (gb !== inj_q[H + i]) begin
                    errors++;
                    $display("FAIL rand%0d_dout[%0d] got %h exp %h", it, i, gb, inj_q[H + i]);
                end
            end
        end
    endtask

`ifdef SPI_ROM_FAST_READ_EN
    task automatic test_fast();
        int tb0, ob0;
        bit ok;
        logic [8:0] g;
        logic [7:0] gb;
        logic [8:0] lit [8];
        lit = '{9'h107, 9'h00B, 9'h000, 9'h000, 9'h000, 9'h0FF, 9'h0FF, 9'h0FF};
        tb0 = tx_log.size();
        ob0 = out_log.size();
        inject(7, 1'b1);
        issue(24'h000000, 2);
        wait_idle(200, ok);
        checks++;
        if (!ok || tx_log.size() - tb0 != 8) begin
            errors++;
            $display("FAIL fast_tx_count got %0d exp 8", tx_log.size() - tb0);
        end
        for (int i = 0; i < 8; i++) begin
            g = (tb0 + i < tx_log.size()) ? tx_log[tb0 + i] : 9'hxxx;
            checks++;
            if (g !== lit[i]) begin
                errors++;
                $display("FAIL fast_tx[%0d] got %h exp %h", i, g, lit[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            gb = (ob0 + i < out_log.size()) ? out_log[ob0 + i] : 8'hxx;
            checks++;
            if (gb !== 8'(8'hA5 + i)) begin
                errors++;
                $display("FAIL fast_dout[%0d] got %h exp %h", i, gb, 8'(8'hA5 + i));
            end
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 24'h0;
        req_len   = 7'd0;
        full_man  = 1'b0;
        ready_man = 1'b1;
        rand_mode = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_reject();
        test_reset_mid();
        test_random();
`ifdef SPI_ROM_FAST_READ_EN
        test_fast();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_rom_reader.md
SPI_ROM_READER -- requirements
Module: spi_rom_reader

Interface
REQ-001 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports req_valid input 1, req_ready output 1: read-request handshake, transfer when both high.
REQ-004 SHALL have ports req_addr input 24 (ROM byte address) and req_len input 7 (data bytes requested).
REQ-005 SHALL have ports tx_data output 9, tx_wr output 1, tx_full input 1: TX FIFO write side; word written when tx_wr=1 and tx_full=0.
REQ-006 SHALL have ports rx_data input 8, rx_rd output 1, rx_empty input 1: RX FIFO read side; rx_data valid the cycle after rx_rd=1 with rx_empty=0.
REQ-007 SHALL have ports dout output 8, dout_valid output 1, dout_ready input 1: read-data stream, transfer when both high.
REQ-008 SHALL have ports busy output 1 (request in progress) and err output 1 (one-cycle reject pulse).

Function
REQ-009 SHALL define H (header bytes) = 4: opcode, addr[23:16], addr[15:8], addr[7:0]; total T = H + req_len.
REQ-010 SHALL accept a request only in IDLE (req_ready=1 in IDLE only); latch addr and len on acceptance.
REQ-011 SHALL reject req_len=0 or T>127: no FIFO traffic, err=1 for one cycle, stay IDLE.
REQ-012 SHALL run states IDLE -> HDR -> CMD -> ADDR2 -> ADDR1 -> ADDR0 -> FILL -> DRAIN -> IDLE, one TX word per state, advancing only on an accepted write.
REQ-013 SHALL write in HDR the word {1'b1, 1'b0, T[6:0]} (command flag, read direction, byte count).
REQ-014 SHALL write in CMD {1'b0, 8'h03}, then address bytes MSB first, each with bit 8 = 0.
REQ-015 SHALL write in FILL {1'b0, 8'hFF} req_len times, counted by a 7-bit down-counter, then enter DRAIN.
REQ-016 SHALL hold tx_wr=1 with stable tx_data while tx_full=1; no word dropped or duplicated.
REQ-017 SHALL run the RX pop process concurrently from HDR until T bytes have been popped, independent of TX progress.
REQ-018 SHALL discard the first H popped bytes (command echo) and present the remaining req_len bytes on dout in order.
REQ-019 SHALL assert rx_rd only when rx_empty=0 and the dout register is empty or is being consumed this cycle; one byte outstanding at most.
REQ-020 SHALL hold dout and dout_valid stable until dout_ready=1.
REQ-021 SHALL leave DRAIN for IDLE the cycle after the last data byte is accepted on dout; busy=1 in every state except IDLE.
REQ-022 SHALL handle simultaneous dout accept and rx pop return in one cycle without a bubble or loss.
REQ-023 SHALL ignore req_valid while busy=1; req_ready=0 then.

Reset
REQ-024 SHALL, on rst=1, drive state IDLE, counters 0, tx_wr=0, rx_rd=0, dout=8'h00, dout_valid=0, busy=0, err=0, req_ready=1 the next cycle.
REQ-025 SHALL abandon any request on rst mid-operation; no further FIFO writes or reads; FIFO flushing is the responsibility of the surrounding system.

Configuration
REQ-026 SHALL support macro SPI_ROM_FAST_READ_EN.
REQ-027 SHALL, with SPI_ROM_FAST_READ_EN defined, use opcode 8'h0B and insert one DUMMY state after ADDR0 writing {1'b0, 8'hFF}, giving H=5 and max req_len 122.
REQ-028 SHALL, without the macro, use opcode 8'h03, no DUMMY state, H=4 and max req_len 123.

Verification
REQ-029 SHALL verify a basic read: addr=24'h001234, len=3, FIFOs never full -> TX words 0x107, 0x003, 0x000, 0x012, 0x034, 0x0FF x3; RX bytes A0..A6 injected -> dout A4, A5, A6; busy returns to 0.
REQ-030 SHALL verify backpressure: tx_full=1 for 5 cycles during ADDR1 -> tx_data=0x012 held, tx_wr held high, TX sequence unchanged.
REQ-031 SHALL verify output stall: dout_ready=0 for 10 cycles with 3 bytes queued in RX -> no rx_rd during the stall, dout stable, no loss after release.
REQ-032 SHALL verify reject: len=0 and len=124 -> err pulse of 1 cycle, tx_wr never asserted, req_ready stays 1.
REQ-033 SHALL verify reset mid-FILL with len=50 -> outputs reach the REQ-024 values the next cycle; a subsequent len=1 request completes correctly.
REQ-034 SHALL verify, with SPI_ROM_FAST_READ_EN, addr=0, len=2 -> TX 0x107, 0x00B, 0x000, 0x000, 0x000, 0x0FF, 0x0FF, 0x0FF; first 5 RX bytes discarded.
